io_port_bank: RTL and testbench

//  Parametrised CPU I/O port bank; successor to the fixed 32-bit in/out register pair.

---
 rtl/io_port_pkg.sv | 31 +++
 rtl/io_in_fifo.sv | 75 +++++++
 rtl/io_port_bank.sv | 110 +++++++++++
 tb/tb_io_port_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants and the seven-segment decode used by the I/O port bank.
package io_port_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_in_fifo.sv
// First-word-fall-through input FIFO with a sticky underflow flag.
module io_in_fifo
  import io_port_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int IN_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ext_valid,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ready,
  input  logic              in_port_rd,
  output logic [DATA_W-1:0] bus_out,
  output logic              in_empty,
  output logic              in_full,
  output logic              rd_err
);

  localparam int AW = $clog2(IN_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(IN_DEPTH);

  logic [DATA_W-1:0] r_mem [IN_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_rd_err;

  logic w_push;
  logic w_pop;
  logic w_pop_err;

  // Handshake: a word transfers on any edge where ext_valid and ext_ready are
  // both high; ext_ready depends only on FIFO occupancy, never on ext_valid.
  assign w_push    = ext_valid & ~in_full;
  assign w_pop     = in_port_rd & ~in_empty;
  assign w_pop_err = in_port_rd & in_empty;

  assign in_empty  = (r_count == '0);
  assign in_full   = (r_count == FULL_CNT);
  assign ext_ready = ~in_full;
  assign bus_out   = in_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_err    = r_rd_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ext_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop_err) begin
        r_rd_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// CPU I/O port bank: FWFT input FIFO, bus-loaded output latch and a
// multiplexed active-low hex seven-segment display of the latch.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int IN_DEPTH   = 4,
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_W-1:0]     bus_in,
  input  logic                  out_port_en,
  input  logic                  in_port_rd,
  input  logic                  ext_valid,
  input  logic [DATA_W-1:0]     ext_data,
  output logic                  ext_ready,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  in_empty,
  output logic                  in_full,
  output logic                  rd_err,
  output logic [DATA_W-1:0]     out_port_q,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] digit_sel_n
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DATA_W-1:0]     r_out_port_q;
  logic [CNT_W-1:0]      r_scan_cnt;
  logic [IDX_W-1:0]      r_digit_idx;
  logic [7:0]            r_seg_n;
  logic [NUM_DIGITS-1:0] r_digit_sel_n;

  logic                  w_scan_wrap;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_digit_onehot;

  io_in_fifo #(
    .DATA_W   (DATA_W),
    .IN_DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk        (clk),
    .clr        (clr),
    .ext_valid  (ext_valid),
    .ext_data   (ext_data),
    .ext_ready  (ext_ready),
    .in_port_rd (in_port_rd),
    .bus_out    (bus_out),
    .in_empty   (in_empty),
    .in_full    (in_full),
    .rd_err     (rd_err)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_out_port_q <= '0;
    end else if (out_port_en) begin
      r_out_port_q <= bus_in;
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      if (w_scan_wrap) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  // Nibble of the latch shown on the currently selected digit.
  always_comb begin
    w_nibble = 4'h0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_digit_idx == IDX_W'(d)) begin
        w_nibble = r_out_port_q[d*4 +: 4];
      end
    end
  end

  assign w_digit_onehot = NUM_DIGITS'(1) << r_digit_idx;

  // Segment and digit drives are registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_seg_n       <= SEG_BLANK;
      r_digit_sel_n <= '1;
    end else begin
      r_seg_n       <= {1'b1, hex7(w_nibble)};
      r_digit_sel_n <= ~w_digit_onehot;
    end
  end

  assign out_port_q  = r_out_port_q;
  assign seg_n       = r_seg_n;
  assign digit_sel_n = r_digit_sel_n;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_io_port_bank;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int ND    = 2;
  localparam int SD    = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [DW-1:0] bus_in = '0;
  logic          out_port_en = 1'b0;
  logic          in_port_rd = 1'b0;
  logic          ext_valid = 1'b0;
  logic [DW-1:0] ext_data = '0;
  logic          ext_ready;
  logic [DW-1:0] bus_out;
  logic          in_empty;
  logic          in_full;
  logic          rd_err;
  logic [DW-1:0] out_port_q;
  logic [7:0]    seg_n;
  logic [ND-1:0] digit_sel_n;

  io_port_bank #(
    .DATA_W     (DW),
    .IN_DEPTH   (DEPTH),
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .bus_in      (bus_in),
    .out_port_en (out_port_en),
    .in_port_rd  (in_port_rd),
    .ext_valid   (ext_valid),
    .ext_data    (ext_data),
    .ext_ready   (ext_ready),
    .bus_out     (bus_out),
    .in_empty    (in_empty),
    .in_full     (in_full),
    .rd_err      (rd_err),
    .out_port_q  (out_port_q),
    .seg_n       (seg_n),
    .digit_sel_n (digit_sel_n)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic          m_rd_err;
  logic [DW-1:0] m_out;
  int            m_edges;
  logic [7:0]    exp_seg;
  logic [ND-1:0] exp_dig;
  logic [6:0]    hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, ".bus_out"},     bus_out, head);
    check({tag, ".in_empty"},    DW'(in_empty), DW'(exp_q.size() == 0));
    check({tag, ".in_full"},     DW'(in_full), DW'(exp_q.size() == DEPTH));
    check({tag, ".ext_ready"},   DW'(ext_ready), DW'(exp_q.size() != DEPTH));
    check({tag, ".rd_err"},      DW'(rd_err), DW'(m_rd_err));
    check({tag, ".out_port_q"},  out_port_q, m_out);
    check({tag, ".seg_n"},       DW'(seg_n), DW'(exp_seg));
    check({tag, ".digit_sel_n"}, DW'(digit_sel_n), DW'(exp_dig));
  endtask

  // One clock with the given inputs; model advanced from the rules, then compared.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic rd, input logic en, input logic [DW-1:0] bi);
    int         n;
    int         digit;
    logic [3:0] nib;
    ext_valid   = v;
    ext_data    = d;
    in_port_rd  = rd;
    out_port_en = en;
    bus_in      = bi;
    digit   = (m_edges / SD) % ND;
    nib     = m_out[4*digit +: 4];
    exp_seg = {1'b1, hex_tab[nib]};
    exp_dig = ~(ND'(1) << digit);
    n = exp_q.size();
    if (rd) begin
      if (n == 0) m_rd_err = 1'b1;
      else void'(exp_q.pop_front());
    end
    if (v && n < DEPTH) exp_q.push_back(d);
    if (en) m_out = bi;
    @(posedge clk);
    #1;
    m_edges++;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) cycle(tag, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Asserts clr away from any clock edge, checks the asynchronous clear, then releases.
  task automatic do_reset(input string tag);
    #2;
    clr = 1'b0;
    ext_valid = 1'b0; in_port_rd = 1'b0; out_port_en = 1'b0;
    exp_q.delete();
    m_rd_err = 1'b0;
    m_out    = '0;
    m_edges  = 0;
    exp_seg  = 8'hFF;
    exp_dig  = '1;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] w;

    // 1: reset and first scan output
    do_reset("t1_reset");
    cycle("t1_first", 1'b0, '0, 1'b0, 1'b0, '0);
    check("t1_seg_const", DW'(seg_n), DW'(8'hC0));
    check("t1_dig_const", DW'(digit_sel_n), DW'(2'b10));

    // 2: fill, held-off 5th word, drain in order
    for (int i = 0; i < 4; i++) cycle("t2_push", 1'b1, 32'hA1 + i, 1'b0, 1'b0, '0);
    check("t2_full_const", DW'(in_full), 32'd1);
    cycle("t2_held", 1'b1, 32'hA5, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle("t2_pop", 1'b0, '0, 1'b1, 1'b0, '0);
    check("t2_empty_const", DW'(in_empty), 32'd1);

    // 3: underflow is sticky
    cycle("t3_underflow", 1'b0, '0, 1'b1, 1'b0, '0);
    idle("t3_hold", 10);

    // 4: push+pop when full and at count 2
    for (int i = 0; i < 4; i++) cycle("t4_fill", 1'b1, $urandom, 1'b0, 1'b0, '0);
    cycle("t4_pp_full", 1'b1, $urandom, 1'b1, 1'b0, '0);
    cycle("t4_pop", 1'b0, '0, 1'b1, 1'b0, '0);
    cycle("t4_pp_two", 1'b1, $urandom, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) cycle("t4_drain", 1'b0, '0, 1'b1, 1'b0, '0);

    // 5: output latch and display scan
    cycle("t5_load", 1'b0, '0, 1'b0, 1'b1, 32'h0000_003F);
    idle("t5_scan", 12);

    // 6: asynchronous clear with words queued mid-scan
    for (int i = 0; i < 3; i++) cycle("t6_push", 1'b1, $urandom, 1'b0, 1'b0, '0);
    cycle("t6_load", 1'b0, '0, 1'b0, 1'b1, $urandom);
    idle("t6_scan", 5);
    do_reset("t6_async_clr");
    idle("t6_after", 3);

    // push+pop on empty: push lands, pop flags error
    cycle("t7_pp_empty", 1'b1, 32'h1234_5678, 1'b1, 1'b0, '0);
    cycle("t7_pop", 1'b0, '0, 1'b1, 1'b0, '0);

    // random traffic
    do_reset("rand_reset");
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      cycle("rand", ($urandom_range(0, 9) < 6), w, ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 2), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
